// File: rtl/word_pack_pkg.sv
// Shared definitions for the word packer/unpacker pair: default widths,
// derived slice count and the two-state handshake FSM encoding.
package word_pack_pkg;

   localparam int unsigned IN_W_DEF  = 16;
   localparam int unsigned OUT_W_DEF = 4;
   localparam int unsigned NSLICE    = IN_W_DEF / OUT_W_DEF;
   localparam int unsigned CNT_W     = $clog2(NSLICE);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Slice count for an arbitrary width pair (instances may override defaults).
   function automatic int unsigned nslice(input int unsigned in_w, input int unsigned out_w);
      return in_w / out_w;
   endfunction

endpackage

// File: rtl/word_unpacker.sv
// Splits one IN_W-bit word into OUT_W-bit slices, most-significant first,
// with valid/ready on both sides and a bubble-free hand-off between words.
module word_unpacker
   import word_pack_pkg::*;
#(
   parameter int unsigned IN_W  = IN_W_DEF,
   parameter int unsigned OUT_W = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   localparam int unsigned NS = nslice(IN_W, OUT_W);
   localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

   if (((IN_W % OUT_W) != 0) || ((IN_W / OUT_W) < 2)) begin : g_param_check
      $fatal(1, "word_unpacker: IN_W must be a multiple of OUT_W with at least 2 slices");
   end

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [IN_W-1:0] hold, hold_n;
   logic            valid_n;
   logic            out_xfer;
   logic            accept;

   assign out_xfer = out_valid && out_ready;
   assign out_last = out_valid && (cnt == CW'(NS - 1));
   assign in_ready = (state == IDLE) || (out_xfer && out_last);
   assign accept   = in_valid && in_ready;
   assign out_data = hold[IN_W-1 -: OUT_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         hold      <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hold      <= hold_n;
         out_valid <= valid_n;
      end
   end

   // A last-slice transfer may reload the holding reg in the same edge.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hold_n  = hold;
      valid_n = out_valid;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = EMIT;
               hold_n  = in_data;
               cnt_n   = '0;
               valid_n = 1'b1;
            end
         end
         EMIT: begin
            if (out_xfer) begin
               if (out_last) begin
                  cnt_n = '0;
                  if (accept) begin
                     hold_n = in_data;
                  end else begin
                     state_n = IDLE;
                     valid_n = 1'b0;
                  end
               end else begin
                  cnt_n  = cnt + CW'(1);
                  hold_n = hold << OUT_W;
               end
            end
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

endmodule
